cache_byte_write_merge: RTL and testbench

- Read-modify-write engine for byte-granular CPU stores that hit in the 2-way set-associative data cache.
- Sits directly upstream of the two per-way synchronous-read data RAMs. It drives their shared address and write-data bus and a per-way write enable, and consumes their read data.
- On a partial-byte write hit, it reads the stored word, merges the enabled bytes and writes the result back.
- On a full-word write hit, it writes directly without the read. On a miss, it touches no RAM and reports the miss.

---
 rtl/cache_byte_write_merge.sv | 125 ++++++++++++
 tb/tb_cache_byte_write_merge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_byte_write_merge.sv
// Byte-granular read-modify-write engine for store hits in a 2-way data cache.
// Partial hits read the stored word, merge enabled bytes and write back;
// full-word hits write directly; misses report back without touching RAM.
module cache_byte_write_merge #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  input  logic                req_hit,
  input  logic                req_way,
  output logic [AWIDTH-1:0]   ram_addr,
  output logic [DWIDTH-1:0]   ram_din,
  output logic                ram_we0,
  output logic                ram_we1,
  input  logic [DWIDTH-1:0]   ram_dout0,
  input  logic [DWIDTH-1:0]   ram_dout1,
  output logic                resp_valid,
  output logic                resp_miss,
  output logic [DWIDTH-1:0]   resp_data
);
  localparam int BWIDTH = DWIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [BWIDTH-1:0]   be_q, be_d;
  logic                hit_q, hit_d;
  logic                way_q, way_d;
  logic [DWIDTH-1:0]   resp_data_q, resp_data_d;
  logic [DWIDTH-1:0]   din_q, din_d;
  logic [DWIDTH-1:0]   rd_word;
  logic [DWIDTH-1:0]   merged;
  logic                accept;

  assign accept = (state_q == IDLE) && req_valid;

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      hit_q       <= 1'b0;
      way_q       <= 1'b0;
      resp_data_q <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      resp_data_q <= resp_data_d;
      din_q       <= din_d;
    end
  end

  // Byte merge: enabled bytes from the store, the rest from the hitting way's read data.
  always_comb begin
    rd_word = way_q ? ram_dout1 : ram_dout0;
    merged  = '0;
    for (int i = 0; i < BWIDTH; i++)
      merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : rd_word[8*i +: 8];
  end

  // Next-state decode plus request latch and response/data register updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    hit_d       = hit_q;
    way_d       = way_q;
    resp_data_d = resp_data_q;
    din_d       = din_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        be_d    = req_be;
        hit_d   = req_hit;
        way_d   = req_way;
        if (!req_hit) begin
          state_d     = RESP;
          resp_data_d = '0;    // miss reports a zero word
        end else if (&req_be) begin
          state_d = WRITE;     // full word: no read needed
        end else begin
          state_d = READ;      // includes be == 0: rewrite the unchanged word
        end
      end
      READ:  state_d = WRITE;
      WRITE: begin
        resp_data_d = merged;
        din_d       = merged;
        state_d     = RESP;
      end
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write enables decode straight from state so reset drops them at once.
  always_comb begin
    req_ready  = (state_q == IDLE);
    ram_addr   = addr_q;
    ram_din    = (state_q == WRITE) ? merged : din_q;
    ram_we0    = (state_q == WRITE) && !way_q;
    ram_we1    = (state_q == WRITE) &&  way_q;
    resp_valid = (state_q == RESP);
    resp_miss  = (state_q == RESP) && !hit_q;
    resp_data  = resp_data_q;
  end

endmodule

// File: tb/tb_cache_byte_write_merge.sv
// Directed bench for cache_byte_write_merge with two behavioural way RAMs.
module tb_cache_byte_write_merge;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          req_hit = 1'b0;
  logic          req_way = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we0, ram_we1;
  logic [DW-1:0] ram_dout0, ram_dout1;
  logic          resp_valid, resp_miss;
  logic [DW-1:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int we0_cnt  = 0;
  int we1_cnt  = 0;

  // preload port into the RAM models
  logic          pl_en = 1'b0;
  logic          pl_way = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  logic [DW-1:0] mem0 [8];
  logic [DW-1:0] mem1 [8];

  cache_byte_write_merge #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_hit(req_hit), .req_way(req_way),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we0(ram_we0), .ram_we1(ram_we1),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1),
    .resp_valid(resp_valid), .resp_miss(resp_miss), .resp_data(resp_data)
  );

  always #5 clock = ~clock;

  // synchronous-read way RAMs (read-before-write)
  always @(posedge clock) begin
    if (pl_en) begin
      if (pl_way) mem1[pl_addr] <= pl_data;
      else        mem0[pl_addr] <= pl_data;
    end else begin
      if (ram_we0) mem0[ram_addr] <= ram_din;
      if (ram_we1) mem1[ram_addr] <= ram_din;
    end
    ram_dout0 <= mem0[ram_addr];
    ram_dout1 <= mem1[ram_addr];
  end

  always @(negedge clock) begin
    if (ram_we0) we0_cnt++;
    if (ram_we1) we1_cnt++;
  end

  task automatic preload(input logic way, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_way = way; pl_addr = a; pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request; latency = negedges after accept until resp_valid (0 = none).
  task automatic run_req(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic hit, input logic way,
                         output int lat, output logic [DW-1:0] rd, output logic miss);
    lat = 0; rd = 'x; miss = 1'bx;
    @(negedge clock);
    we0_cnt = 0; we1_cnt = 0;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_be = be;
    req_hit = hit; req_way = way;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = i; rd = resp_data; miss = resp_miss;
        break;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({req_ready, ram_we0, ram_we1, resp_valid, resp_miss} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 10000",
                         {req_ready, ram_we0, ram_we1, resp_valid, resp_miss});
    end
    n_checks++;
    if (resp_data !== '0 || ram_addr !== '0 || ram_din !== '0) begin
      n_fail++; $display("FAIL reset_data: resp_data %h ram_addr %h ram_din %h expected 0",
                         resp_data, ram_addr, ram_din);
    end
  endtask

  task automatic test_partial_way0();
    int lat; logic [DW-1:0] rd; logic m;
    preload(1'b0, 3'd5, 32'hAABBCCDD);
    run_req(3'd5, 32'h11223344, 4'b0101, 1'b1, 1'b0, lat, rd, m);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL partial_latency: got %0d expected 3", lat); end
    n_checks++;
    if (rd !== 32'hAA22CC44) begin n_fail++; $display("FAIL partial_data: got %h expected aa22cc44", rd); end
    n_checks++;
    if (mem0[5] !== 32'hAA22CC44) begin n_fail++; $display("FAIL partial_ram: got %h expected aa22cc44", mem0[5]); end
    n_checks++;
    if (we1_cnt !== 0 || we0_cnt !== 1) begin
      n_fail++; $display("FAIL partial_we: we0 %0d we1 %0d expected 1 0", we0_cnt, we1_cnt);
    end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL partial_pulse: resp_valid %b expected 0", resp_valid); end
  endtask

  task automatic test_full_way1();
    int lat; logic [DW-1:0] rd; logic m;
    preload(1'b1, 3'd2, 32'h0);
    run_req(3'd2, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, lat, rd, m);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL full_latency: got %0d expected 2", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF || m !== 1'b0) begin
      n_fail++; $display("FAIL full_resp: data %h miss %b expected deadbeef 0", rd, m);
    end
    n_checks++;
    if (mem1[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_ram: got %h expected deadbeef", mem1[2]); end
    n_checks++;
    if (we1_cnt !== 1 || we0_cnt !== 0) begin
      n_fail++; $display("FAIL full_we: we0 %0d we1 %0d expected 0 1", we0_cnt, we1_cnt);
    end
  endtask

  task automatic test_miss();
    int lat; logic [DW-1:0] rd; logic m;
    preload(1'b0, 3'd7, 32'h0BADF00D);
    preload(1'b1, 3'd7, 32'hFEEDFACE);
    run_req(3'd7, 32'h55555555, 4'h3, 1'b0, 1'b1, lat, rd, m);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL miss_latency: got %0d expected 1", lat); end
    n_checks++;
    if (m !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL miss_resp: miss %b data %h expected 1 0", m, rd);
    end
    n_checks++;
    if (we0_cnt !== 0 || we1_cnt !== 0) begin
      n_fail++; $display("FAIL miss_we: we0 %0d we1 %0d expected 0 0", we0_cnt, we1_cnt);
    end
    n_checks++;
    if (mem0[7] !== 32'h0BADF00D || mem1[7] !== 32'hFEEDFACE) begin
      n_fail++; $display("FAIL miss_ram: way0 %h way1 %h expected 0badf00d feedface", mem0[7], mem1[7]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [DW-1:0] rd;
    preload(1'b0, 3'd1, 32'h01020304);
    preload(1'b1, 3'd6, 32'h55667788);
    @(negedge clock);
    req_valid = 1'b1; req_addr = 3'd1; req_wdata = 32'hA0B0C0D0; req_be = 4'b1000;
    req_hit = 1'b1; req_way = 1'b0;
    @(posedge clock); #1;
    // present the next request immediately and keep valid high
    req_addr = 3'd6; req_wdata = 32'h99000000; req_way = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy c%0d: got %b expected 0", i, req_ready); end
    end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hA0020304) begin
      n_fail++; $display("FAIL b2b_first: valid %b data %h expected 1 a0020304", resp_valid, resp_data);
    end
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b expected 1", req_ready); end
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0; rd = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (resp_valid) begin lat = i; rd = resp_data; break; end
    end
    n_checks++;
    if (lat !== 3 || rd !== 32'h99667788) begin
      n_fail++; $display("FAIL b2b_second: lat %0d data %h expected 3 99667788", lat, rd);
    end
    n_checks++;
    if (mem0[1] !== 32'hA0020304 || mem1[6] !== 32'h99667788) begin
      n_fail++; $display("FAIL b2b_ram: way0[1] %h way1[6] %h expected a0020304 99667788", mem0[1], mem1[6]);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    preload(1'b0, 3'd3, 32'hCAFEF00D);
    @(negedge clock);
    req_valid = 1'b1; req_addr = 3'd3; req_wdata = 32'h000000FF; req_be = 4'b0001;
    req_hit = 1'b1; req_way = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);   // READ
    @(negedge clock);   // WRITE
    n_checks++;
    if (ram_we0 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we0: got %b expected 1", ram_we0); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ram_we0 !== 1'b0 || ram_we1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_we: we0 %b we1 %b expected 0 0", ram_we0, ram_we1);
    end
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: ready %b resp_valid %b expected 1 0", req_ready, resp_valid);
    end
    @(negedge clock);
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp: resp_valid %b expected 0", resp_valid); end
    n_checks++;
    if (mem0[3] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_ram: got %h expected cafef00d", mem0[3]); end
  endtask

  task automatic test_be_zero();
    int lat; logic [DW-1:0] rd; logic m;
    preload(1'b1, 3'd0, 32'h12345678);
    run_req(3'd0, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, lat, rd, m);
    n_checks++;
    if (lat !== 3 || rd !== 32'h12345678) begin
      n_fail++; $display("FAIL be0_resp: lat %0d data %h expected 3 12345678", lat, rd);
    end
    n_checks++;
    if (we1_cnt !== 1 || we0_cnt !== 0) begin
      n_fail++; $display("FAIL be0_we: we0 %0d we1 %0d expected 0 1", we0_cnt, we1_cnt);
    end
    n_checks++;
    if (mem1[0] !== 32'h12345678) begin n_fail++; $display("FAIL be0_ram: got %h expected 12345678", mem1[0]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    #22 reset_n = 1'b1;
    test_reset();
    test_partial_way0();
    test_full_way1();
    test_miss();
    test_back_to_back();
    test_reset_mid_op();
    test_be_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
